// File: rtl/seq_mult8_if.sv
// Start/Busy/Done handshake and operand/result bus between the sequencer and seq_mult8.
interface seq_mult8_if;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;

  modport master (output Start, A, B, input Busy, Done, Product);
  modport slave  (input Start, A, B, output Busy, Done, Product);
endinterface

// File: rtl/seq_mult8.sv
// Sequential 8x8 shift-and-add multiplier: one 16-bit product every 10 cycles.
// Optional two's complement operation when SEQ_MULT8_SIGNED_EN is defined.
module seq_mult8 (
  input logic        Clk,
  input logic        Rst_n,
  seq_mult8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] product_q, product_d;
  logic [7:0]  a_cap, b_cap;
  logic [15:0] raw_prod, fin_prod;

  // CLA8bit datapath: generate/propagate with flattened lookahead carries
  logic [7:0] cla_g, cla_p, cla_s;
  logic [8:0] cla_c;
  logic       term;
  logic [8:0] step_sum;

  always_comb begin
    cla_g = acc_hi_q & mcand_q;
    cla_p = acc_hi_q ^ mcand_q;
    cla_c = '0;
    term  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < k; j++) begin
        term = cla_g[j];
        for (int m = j + 1; m < k; m++) term = term & cla_p[m];
        cla_c[k] = cla_c[k] | term;
      end
    end
    cla_s    = cla_p ^ cla_c[7:0];
    step_sum = mplier_q[0] ? {cla_c[8], cla_s} : {1'b0, acc_hi_q};
  end

  assign raw_prod = {acc_hi_q, mplier_q};

`ifdef SEQ_MULT8_SIGNED_EN
  logic sign_q, sign_d;
  // abs(-128) wraps to 8'h80, which the unsigned core handles correctly
  assign a_cap    = bus.A[7] ? (~bus.A + 8'd1) : bus.A;
  assign b_cap    = bus.B[7] ? (~bus.B + 8'd1) : bus.B;
  assign fin_prod = sign_q ? (~raw_prod + 16'd1) : raw_prod;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end

  always_comb begin
    sign_d = sign_q;
    if (state_q == IDLE && bus.Start) sign_d = bus.A[7] ^ bus.B[7];
  end
`else
  assign a_cap    = bus.A;
  assign b_cap    = bus.B;
  assign fin_prod = raw_prod;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_hi_q  <= acc_hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_hi_d  = acc_hi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mcand_d  = a_cap;
          mplier_d = b_cap;
          acc_hi_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        // 17-bit right shift of {carry, sum, multiplier}
        {acc_hi_d, mplier_d} = {step_sum, mplier_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        product_d = fin_prod;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Product = product_q;
endmodule

// File: tb/tb_seq_mult8.sv
// Directed + randomized bench for seq_mult8 against an arithmetic reference model.
module tb_seq_mult8;
  logic Clk;
  logic Rst_n;
  int   tests;
  int   fails;

  seq_mult8_if bus ();

  seq_mult8 dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int r;
`ifdef SEQ_MULT8_SIGNED_EN
    r = int'($signed(a)) * int'($signed(b));
`else
    r = int'(a) * int'(b);
`endif
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an operation so that the next rising edge (E0) accepts it.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit hold);
    bus.A = a;
    bus.B = b;
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    if (!hold) bus.Start = 1'b0;
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
    chk("busy_after_E0", {15'd0, bus.Busy}, 16'd1);
  endtask

  // Called at E0+1; returns in the Done cycle (E9+1).
  task automatic wait_done(input logic [15:0] exp, input string tag, input bit scramble);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge Clk); #1;
      n++;
      if (bus.Done) seen = 1'b1;
      else if (scramble) begin
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
      end
    end
    chk({tag, "_done_seen"}, {15'd0, seen}, 16'd1);
    chk({tag, "_latency"}, 16'(n), 16'd9);
    chk({tag, "_product"}, bus.Product, exp);
    chk({tag, "_busy_low"}, {15'd0, bus.Busy}, 16'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int seen_done;
    tests = 0;
    fails = 0;
    Rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("rst_busy", {15'd0, bus.Busy}, 16'd0);
    chk("rst_done", {15'd0, bus.Done}, 16'd0);
    chk("rst_product", bus.Product, 16'd0);
    #2 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("idle_busy", {15'd0, bus.Busy}, 16'd0);

    // basic 13*11
    issue(8'd13, 8'd11, 1'b0);
    wait_done(model(8'd13, 8'd11), "m13x11", 1'b0);
    chk("m13x11_const", bus.Product, 16'h008F);
    @(posedge Clk); #1;
    chk("done_one_cycle", {15'd0, bus.Done}, 16'd0);
    chk("product_holds", bus.Product, 16'h008F);

    // extremes, back-to-back: each issued in the previous Done cycle
    issue(8'd255, 8'd255, 1'b0);
    wait_done(model(8'd255, 8'd255), "m255x255", 1'b0);
    issue(8'd0, 8'd200, 1'b0);
    wait_done(model(8'd0, 8'd200), "m0x200", 1'b0);
    issue(8'd1, 8'd255, 1'b0);
    wait_done(model(8'd1, 8'd255), "m1x255", 1'b0);
`ifndef SEQ_MULT8_SIGNED_EN
    chk("m1x255_const", bus.Product, 16'h00FF);
`endif

    // Start held high with operands scrambled during CALC
    issue(8'd37, 8'd201, 1'b1);
    wait_done(model(8'd37, 8'd201), "hold", 1'b1);
    bus.A = 8'd19;
    bus.B = 8'd23;
    @(posedge Clk); #1;
    chk("hold_reaccept_busy", {15'd0, bus.Busy}, 16'd1);
    chk("hold_no_extra_done", {15'd0, bus.Done}, 16'd0);
    bus.Start = 1'b0;
    wait_done(model(8'd19, 8'd23), "hold2", 1'b1);

    // asynchronous reset at E4 of 100*100
    @(posedge Clk); #1;
    issue(8'd100, 8'd100, 1'b0);
    repeat (4) begin @(posedge Clk); #1; end
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'd0, bus.Busy}, 16'd0);
    chk("midrst_done", {15'd0, bus.Done}, 16'd0);
    chk("midrst_product", bus.Product, 16'd0);
    #2 Rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (bus.Done) seen_done++;
    end
    chk("midrst_no_done", 16'(seen_done), 16'd0);
    issue(8'd7, 8'd6, 1'b0);
    wait_done(model(8'd7, 8'd6), "m7x6", 1'b0);
    chk("m7x6_const", bus.Product, 16'h002A);

    // 0xFD * 5: unsigned 1265, signed -15
    issue(8'hFD, 8'd5, 1'b0);
    wait_done(model(8'hFD, 8'd5), "mFDx5", 1'b0);
`ifdef SEQ_MULT8_SIGNED_EN
    chk("mFDx5_const", bus.Product, 16'hFFF1);
    issue(8'h80, 8'h80, 1'b0);
    wait_done(16'h4000, "s_m128xm128", 1'b0);
    issue(8'h80, 8'h01, 1'b0);
    wait_done(16'hFF80, "s_m128x1", 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    wait_done(16'hFF81, "s_127xm1", 1'b0);
`else
    chk("mFDx5_const", bus.Product, 16'h04F1);
`endif

    // random operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(ra, rb, 1'b0);
      wait_done(model(ra, rb), "rand", (i % 2) == 1);
      repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
